ram_copier: RTL and testbench

RAM_COPIER -- requirements
Module: RamCopier

---
 rtl/ram_copier_if.sv | 30 +++
 rtl/ram_copier.sv | 95 +++++++++
 tb/tb_ram_copier.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/ram_copier_if.sv
// ram_copier_if: job request/status and RAM port bundle for the copy/fill engine
interface ram_copier_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
);
    logic              start_i;
    logic              mode_i;
    logic [ADDR_W-1:0] src_i;
    logic [ADDR_W-1:0] dst_i;
    logic [ADDR_W:0]   len_i;
    logic [DATA_W-1:0] fill_i;
    logic              abort_i;
    logic              busy_o;
    logic              done_o;
    logic              ram_rden_o;
    logic              ram_wren_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [DATA_W-1:0] ram_wdata_o;
    logic [DATA_W-1:0] ram_rdata_i;

    modport slave (
        input  start_i, mode_i, src_i, dst_i, len_i, fill_i, abort_i, ram_rdata_i,
        output busy_o, done_o, ram_rden_o, ram_wren_o, ram_addr_o, ram_wdata_o
    );

    modport master (
        output start_i, mode_i, src_i, dst_i, len_i, fill_i, abort_i, ram_rdata_i,
        input  busy_o, done_o, ram_rden_o, ram_wren_o, ram_addr_o, ram_wdata_o
    );
endinterface

// File: rtl/ram_copier.sv
// ram_copier: memmove-style RAM copy / pattern fill engine with abort
module ram_copier #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input logic         clk,
    input logic         rst,
    ram_copier_if.slave bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] READ  = 3'd1;
    localparam logic [2:0] WRITE = 3'd2;
    localparam logic [2:0] FILLW = 3'd3;
    localparam logic [2:0] FIN   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              desc_q, desc_d;
    logic [DATA_W-1:0] fill_q, fill_d;
    logic [ADDR_W-1:0] diff, len_lo, step;
    logic              desc_new, last;

    // overlap where the destination lies inside the source window forces a top-down copy
    assign diff     = bus.dst_i - bus.src_i;
    assign len_lo   = bus.len_i[ADDR_W-1:0];
    assign desc_new = {1'b0, diff} < bus.len_i;
    assign last     = cnt_q == (ADDR_W+1)'(1);
    assign step     = desc_q ? {ADDR_W{1'b1}} : ADDR_W'(1);

    // next-state and job bookkeeping; the base address of a descending job is its top word
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        desc_d  = desc_q;
        fill_d  = fill_q;
        case (state_q)
            IDLE: if (bus.start_i) begin
                desc_d  = !bus.mode_i && desc_new;
                src_d   = desc_d ? bus.src_i + len_lo - ADDR_W'(1) : bus.src_i;
                dst_d   = desc_d ? bus.dst_i + len_lo - ADDR_W'(1) : bus.dst_i;
                cnt_d   = bus.len_i;
                fill_d  = bus.fill_i;
                state_d = (bus.len_i == '0) ? FIN :
                          bus.mode_i ? FILLW :
                          (bus.src_i != bus.dst_i) ? READ : FIN;
            end
            READ: begin
                src_d   = src_q + step;
                state_d = bus.abort_i ? IDLE : WRITE;
            end
            WRITE: begin
                dst_d   = dst_q + step;
                cnt_d   = cnt_q - 1'b1;
                state_d = bus.abort_i ? IDLE : last ? FIN : READ;
            end
            FILLW: begin
                dst_d   = dst_q + step;
                cnt_d   = cnt_q - 1'b1;
                state_d = bus.abort_i ? IDLE : last ? FIN : FILLW;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and latched job registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            desc_q  <= 1'b0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            desc_q  <= desc_d;
            fill_q  <= fill_d;
        end
    end

    // outputs decode from state only, so reset clears them without waiting for a clock
    assign bus.busy_o      = state_q == READ || state_q == WRITE || state_q == FILLW;
    assign bus.done_o      = state_q == FIN;
    assign bus.ram_rden_o  = state_q == READ;
    assign bus.ram_wren_o  = state_q == WRITE || state_q == FILLW;
    assign bus.ram_addr_o  = (state_q == READ) ? src_q : bus.ram_wren_o ? dst_q : '0;
    assign bus.ram_wdata_o = (state_q == WRITE) ? bus.ram_rdata_i :
                             (state_q == FILLW) ? fill_q : '0;
endmodule

// File: tb/tb_ram_copier.sv
// tb_ram_copier: table-driven jobs with a write scoreboard plus abort/reset/busy-start sequences
module tb_ram_copier;
    localparam int AW = 12;
    localparam int DW = 16;
    localparam int N  = 1 << AW;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        logic          mode;
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        logic [AW:0]   len;
        logic [DW-1:0] fill;
        int            exp_done;
        logic [AW-1:0] exp_first;
        bit            inj;
        bit            ab;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int failures = 0;
    logic [DW-1:0] mem [N];
    wr_t exp_q[$];
    vec_t vecs[10];

    always #5 clk = ~clk;

    ram_copier_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
    ram_copier #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    // RAM model: one-cycle read latency, data held until the next read; pattern reloads in reset
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) mem[i] <= DW'(i * 37) ^ 16'h5a5a;
        end else begin
            if (bus.ram_wren_o) mem[bus.ram_addr_o] <= bus.ram_wdata_o;
            if (bus.ram_rden_o) bus.ram_rdata_i <= mem[bus.ram_addr_o];
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic run_job(input vec_t v);
        int n_rd = 0, n_wr = 0, done_at = -1, idx;
        bit active, desc, prev_rd = 0, got_first = 0;
        logic [AW-1:0] first = '0, diff;
        wr_t e;
        exp_q.delete();
        active = v.len != 0 && (v.mode || v.src != v.dst);
        diff = v.dst - v.src;
        desc = !v.mode && ({1'b0, diff} < v.len);
        if (active) begin
            for (int k = 0; k < int'(v.len); k++) begin
                idx = desc ? int'(v.len) - 1 - k : k;
                e.addr = v.dst + AW'(idx);
                e.data = v.mode ? v.fill : mem[v.src + AW'(idx)];
                exp_q.push_back(e);
            end
        end
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.mode_i  = v.mode;
        bus.src_i   = v.src;
        bus.dst_i   = v.dst;
        bus.len_i   = v.len;
        bus.fill_i  = v.fill;
        bus.abort_i = v.ab;
        @(posedge clk);
        for (int n = 1; n <= v.exp_done + 20; n++) begin
            @(negedge clk);
            if (n == 1) begin
                bus.start_i = 1'b0;
                bus.abort_i = 1'b0;
            end
            if (v.inj && n == 2) begin
                bus.start_i = 1'b1;
                bus.mode_i  = 1'b1;
                bus.dst_i   = v.dst;
                bus.len_i   = 13'd2;
                bus.fill_i  = 16'hdead;
            end
            if (v.inj && n == 3) bus.start_i = 1'b0;
            if (bus.ram_rden_o || bus.ram_wren_o) begin
                check("rd_wr_excl", {31'b0, bus.ram_rden_o & bus.ram_wren_o}, 32'd0);
                if (!got_first) first = bus.ram_addr_o;
                got_first = 1;
            end
            if (bus.ram_rden_o) n_rd++;
            if (bus.ram_wren_o) begin
                n_wr++;
                if (exp_q.size() == 0) begin
                    check("extra_write", 32'(bus.ram_addr_o), 32'hffff_ffff);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(bus.ram_addr_o), 32'(e.addr));
                    check("wr_data", 32'(bus.ram_wdata_o), 32'(e.data));
                    if (!v.mode) check("alternate", {31'b0, prev_rd}, 32'd1);
                end
            end
            prev_rd = bus.ram_rden_o;
            if (bus.done_o) begin
                check("busy_in_fin", {31'b0, bus.busy_o}, 32'd0);
                done_at = n;
                break;
            end
        end
        check("done_cycle", 32'(done_at), 32'(v.exp_done));
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("reads", 32'(n_rd), (active && !v.mode) ? 32'(v.len) : 32'd0);
        check("writes", 32'(n_wr), active ? 32'(v.len) : 32'd0);
        if (active) check("first_addr", 32'(first), 32'(v.exp_first));
        @(negedge clk);
        check("done_pulse", {30'b0, bus.done_o, bus.busy_o}, 32'd0);
    endtask

    initial begin
        int n_wr, cyc;
        bit aborted, saw_done, saw_strobe;
        logic [DW-1:0] orig2, orig3;
        bus.start_i = 0; bus.mode_i = 0; bus.src_i = '0; bus.dst_i = '0;
        bus.len_i = '0; bus.fill_i = '0; bus.abort_i = 0;
        // mode  src      dst      len       fill      done  first    inj ab
        vecs[0] = '{1'b0, 12'h010, 12'h100, 13'd4,    16'h0,    9,    12'h010, 0, 0};
        vecs[1] = '{1'b0, 12'h000, 12'h002, 13'd4,    16'h0,    9,    12'h003, 0, 0};
        vecs[2] = '{1'b1, 12'h000, 12'hffe, 13'd4,    16'hbeef, 5,    12'hffe, 0, 0};
        vecs[3] = '{1'b0, 12'h030, 12'h040, 13'd0,    16'h0,    1,    12'h000, 0, 0};
        vecs[4] = '{1'b0, 12'h050, 12'h050, 13'd5,    16'h0,    1,    12'h000, 0, 0};
        vecs[5] = '{1'b1, 12'h000, 12'h060, 13'd0,    16'h1111, 1,    12'h000, 0, 0};
        vecs[6] = '{1'b0, 12'hffe, 12'h000, 13'd3,    16'h0,    7,    12'h000, 0, 0};
        vecs[7] = '{1'b0, 12'h020, 12'h01e, 13'd4,    16'h0,    9,    12'h020, 0, 0};
        vecs[8] = '{1'b1, 12'h000, 12'h123, 13'd4096, 16'h7e7e, 4097, 12'h123, 0, 0};
        vecs[9] = '{1'b0, 12'h400, 12'h410, 13'd4,    16'h0,    9,    12'h400, 1, 0};

        #1 rst = 1'b1;
        #1;
        check("rst_busy",  {31'b0, bus.busy_o}, 32'd0);
        check("rst_done",  {31'b0, bus.done_o}, 32'd0);
        check("rst_rden",  {31'b0, bus.ram_rden_o}, 32'd0);
        check("rst_wren",  {31'b0, bus.ram_wren_o}, 32'd0);
        check("rst_addr",  32'(bus.ram_addr_o), 32'd0);
        check("rst_wdata", 32'(bus.ram_wdata_o), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 10; i++) run_job(vecs[i]);
        run_job('{1'b1, 12'h000, 12'h500, 13'd3, 16'h1234, 4, 12'h500, 0, 1});

        // abort during the third write of an 8-word copy
        orig2 = mem[12'h202];
        orig3 = mem[12'h303];
        @(negedge clk);
        bus.start_i = 1; bus.mode_i = 0; bus.src_i = 12'h200; bus.dst_i = 12'h300; bus.len_i = 13'd8;
        @(posedge clk);
        n_wr = 0; aborted = 0; saw_done = 0; cyc = -5;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            bus.start_i = 0;
            if (aborted) bus.abort_i = 0;
            if (n == cyc + 1) check("abort_idle", {31'b0, bus.busy_o}, 32'd0);
            if (bus.ram_wren_o) n_wr++;
            if (bus.done_o) saw_done = 1;
            if (!aborted && bus.ram_wren_o && n_wr == 3) begin
                bus.abort_i = 1;
                aborted = 1;
                cyc = n;
            end
        end
        check("abort_seen", {31'b0, aborted}, 32'd1);
        check("abort_writes", 32'(n_wr), 32'd3);
        check("abort_no_done", {31'b0, saw_done}, 32'd0);
        check("abort_last_word", 32'(mem[12'h302]), 32'(orig2));
        check("abort_untouched", 32'(mem[12'h303]), 32'(orig3));

        // asynchronous reset between edges in the middle of a fill
        @(negedge clk);
        bus.start_i = 1; bus.mode_i = 1; bus.dst_i = 12'h600; bus.len_i = 13'd8; bus.fill_i = 16'hc3c3;
        @(posedge clk);
        @(negedge clk) bus.start_i = 0;
        @(negedge clk);
        check("pre_rst_busy", {31'b0, bus.busy_o}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_outs", {bus.busy_o, bus.done_o, bus.ram_rden_o, bus.ram_wren_o,
                               bus.ram_addr_o, bus.ram_wdata_o}, 32'd0);
        @(negedge clk) rst = 1'b0;
        saw_done = 0; saw_strobe = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done_o) saw_done = 1;
            if (bus.busy_o || bus.ram_rden_o || bus.ram_wren_o) saw_strobe = 1;
        end
        check("rst_no_done", {31'b0, saw_done}, 32'd0);
        check("rst_idle", {31'b0, saw_strobe}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
